// File: rtl/ariane_pkg.sv
// Shared store-buffer types and default queue depths.
package ariane_pkg;

   localparam int unsigned DEFAULT_SPEC_DEPTH   = 4;
   localparam int unsigned DEFAULT_COMMIT_DEPTH = 8;

   typedef struct packed {
      logic [55:0] address;
      logic [63:0] data;
      logic [7:0]  be;
      logic [1:0]  size;
   } store_entry_t;

endpackage

// File: rtl/lsu_store_buffer_sb_queue.sv
// Circular store FIFO with clear; exposes per-entry valid and page-offset bits for hazard matching.
module sb_queue
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  store_entry_t             entry_i,
   input  logic                     pop_i,
   output store_entry_t             head_o,
   output logic [CW-1:0]            cnt_o,
   output logic [DEPTH-1:0]         valid_o,
   output logic [DEPTH-1:0][8:0]    page_o
);

   store_entry_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic [DEPTH-1:0] valid;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         valid  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clear_i) begin
         // storage is left as-is; cleared valid bits hide stale entries
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         valid  <= '0;
      end else begin
         if (push_i) begin
            mem[wr_ptr]   <= entry_i;
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop_i) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_comb begin
      page_o = '0;
      for (int i = 0; i < int'(DEPTH); i++) page_o[i] = mem[i].address[11:3];
   end

   assign head_o  = mem[rd_ptr];
   assign cnt_o   = cnt;
   assign valid_o = valid;

endmodule

// File: rtl/lsu_store_buffer.sv
// Two-stage store buffer: speculative queue feeding a committed queue that drains to the dcache.
module lsu_store_buffer
   import ariane_pkg::*;
#(
   parameter int unsigned SPEC_DEPTH   = DEFAULT_SPEC_DEPTH,
   parameter int unsigned COMMIT_DEPTH = DEFAULT_COMMIT_DEPTH
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         valid_i,
   input  store_entry_t entry_i,
   output logic         ready_o,
   input  logic         commit_i,
   output logic         commit_ready_o,
   input  logic [11:0]  page_offset_i,
   output logic         page_offset_matches_o,
   output logic         no_st_pending_o,
   output logic         mem_req_o,
   input  logic         mem_gnt_i,
   output store_entry_t mem_entry_o
);

   localparam int unsigned SCW = $clog2(SPEC_DEPTH) + 1;
   localparam int unsigned CCW = $clog2(COMMIT_DEPTH) + 1;

   logic [SCW-1:0]                 spec_cnt;
   logic [CCW-1:0]                 commit_cnt;
   store_entry_t                   spec_head;
   logic [SPEC_DEPTH-1:0]          spec_valid;
   logic [SPEC_DEPTH-1:0][8:0]     spec_page;
   logic [COMMIT_DEPTH-1:0]        commit_valid;
   logic [COMMIT_DEPTH-1:0][8:0]   commit_page;
   logic                           spec_push;
   logic                           commit_move;
   logic                           mem_pop;
   logic                           unused_offset_bits;

   assign ready_o         = (spec_cnt != SCW'(SPEC_DEPTH));
   assign commit_ready_o  = (commit_cnt != CCW'(COMMIT_DEPTH));
   assign mem_req_o       = (commit_cnt != '0);
   assign no_st_pending_o = (spec_cnt == '0) && (commit_cnt == '0);

   // flush wins over both same-cycle push and commit
   assign spec_push   = valid_i && ready_o && !flush_i;
   assign commit_move = commit_i && (spec_cnt != '0) && commit_ready_o && !flush_i;
   assign mem_pop     = mem_req_o && mem_gnt_i;

   sb_queue #(.DEPTH(SPEC_DEPTH)) i_spec_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_i),
      .push_i  (spec_push),
      .entry_i (entry_i),
      .pop_i   (commit_move),
      .head_o  (spec_head),
      .cnt_o   (spec_cnt),
      .valid_o (spec_valid),
      .page_o  (spec_page)
   );

   sb_queue #(.DEPTH(COMMIT_DEPTH)) i_commit_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (1'b0),
      .push_i  (commit_move),
      .entry_i (spec_head),
      .pop_i   (mem_pop),
      .head_o  (mem_entry_o),
      .cnt_o   (commit_cnt),
      .valid_o (commit_valid),
      .page_o  (commit_page)
   );

   always_comb begin
      page_offset_matches_o = 1'b0;
      for (int i = 0; i < int'(SPEC_DEPTH); i++)
         if (spec_valid[i] && (spec_page[i] == page_offset_i[11:3])) page_offset_matches_o = 1'b1;
      for (int i = 0; i < int'(COMMIT_DEPTH); i++)
         if (commit_valid[i] && (commit_page[i] == page_offset_i[11:3])) page_offset_matches_o = 1'b1;
   end

   assign unused_offset_bits = ^page_offset_i[2:0];

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(valid_i && !ready_o && !flush_i))
            else $warning("store dropped: speculative queue full");
         assert (!(commit_i && !flush_i && ((spec_cnt == '0) || !commit_ready_o)))
            else $warning("commit ignored: nothing to commit or committed queue full");
      end
   end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: vector table plus hand sequences for full-queue, flush and reset cases.
module tb_lsu_store_buffer;
   import ariane_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         flush_i;
   logic         valid_i;
   store_entry_t entry_i;
   logic         ready_o;
   logic         commit_i;
   logic         commit_ready_o;
   logic [11:0]  page_offset_i;
   logic         page_offset_matches_o;
   logic         no_st_pending_o;
   logic         mem_req_o;
   logic         mem_gnt_i;
   store_entry_t mem_entry_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   lsu_store_buffer dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .valid_i               (valid_i),
      .entry_i               (entry_i),
      .ready_o               (ready_o),
      .commit_i              (commit_i),
      .commit_ready_o        (commit_ready_o),
      .page_offset_i         (page_offset_i),
      .page_offset_matches_o (page_offset_matches_o),
      .no_st_pending_o       (no_st_pending_o),
      .mem_req_o             (mem_req_o),
      .mem_gnt_i             (mem_gnt_i),
      .mem_entry_o           (mem_entry_o)
   );

   typedef struct {
      logic        flush, valid, commit, gnt;
      logic [55:0] addr;
      logic [11:0] poff;
      logic        ready, cready, req;
      logic [55:0] maddr;
      logic        nop, match;
   } vec_t;

   vec_t vecs [23];

   function automatic vec_t mk(input logic f, v, c, g, input logic [55:0] a, input logic [11:0] p,
                               input logic r, cr, rq, input logic [55:0] ma, input logic np, m);
      vec_t t;
      t.flush = f; t.valid = v; t.commit = c; t.gnt = g; t.addr = a; t.poff = p;
      t.ready = r; t.cready = cr; t.req = rq; t.maddr = ma; t.nop = np; t.match = m;
      return t;
   endfunction

   function automatic store_entry_t mk_entry(input logic [55:0] a);
      store_entry_t e;
      e.address = a;
      e.data    = {8'hA5, a};
      e.be      = 8'hFF;
      e.size    = 2'b11;
      return e;
   endfunction

   task automatic check(input string name, input logic ok, input string detail);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [55:0] a);
      valid_i = 1'b1;
      entry_i = mk_entry(a);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic do_commit();
      commit_i = 1'b1;
      tick();
      commit_i = 1'b0;
   endtask

   // Holds the grant for n cycles expecting consecutive addresses, then expects the request to drop.
   task automatic drain_expect(input string name, input int n, input logic [55:0] base);
      logic [55:0] exp_addr;
      mem_gnt_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp_addr = base + 56'(8 * i);
         check($sformatf("%s_%0d", name, i), mem_req_o && (mem_entry_o.address == exp_addr),
               $sformatf("got req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_entry_o.address, exp_addr));
         tick();
      end
      mem_gnt_i = 1'b0;
      #1;
      check($sformatf("%s_end", name), !mem_req_o,
            $sformatf("got req=%0b, want req=0", mem_req_o));
   endtask

   initial begin
      vecs[0]  = mk(0,0,0,0,56'h0,   12'hFF8, 1,1,0,56'h0,   1,0);
      vecs[1]  = mk(0,1,0,0,56'h1000,12'hFF8, 1,1,0,56'h0,   1,0);
      vecs[2]  = mk(0,1,0,0,56'h1008,12'hFF8, 1,1,0,56'h0,   0,0);
      vecs[3]  = mk(0,1,0,0,56'h1010,12'hFF8, 1,1,0,56'h0,   0,0);
      vecs[4]  = mk(0,1,0,0,56'h1018,12'hFF8, 1,1,0,56'h0,   0,0);
      vecs[5]  = mk(0,1,0,0,56'h1020,12'h018, 0,1,0,56'h0,   0,1);
      vecs[6]  = mk(0,0,0,0,56'h0,   12'h020, 0,1,0,56'h0,   0,0);
      vecs[7]  = mk(0,1,1,0,56'h1030,12'hFF8, 0,1,0,56'h0,   0,0);
      vecs[8]  = mk(0,0,1,0,56'h0,   12'hFF8, 1,1,1,56'h1000,0,0);
      vecs[9]  = mk(0,0,0,0,56'h0,   12'hFF8, 1,1,1,56'h1000,0,0);
      vecs[10] = mk(0,0,0,0,56'h0,   12'hFF8, 1,1,1,56'h1000,0,0);
      vecs[11] = mk(0,0,0,1,56'h0,   12'hFF8, 1,1,1,56'h1000,0,0);
      vecs[12] = mk(0,1,1,0,56'h1040,12'hFF8, 1,1,1,56'h1008,0,0);
      vecs[13] = mk(0,1,0,0,56'h1048,12'h010, 1,1,1,56'h1008,0,1);
      vecs[14] = mk(1,1,1,0,56'h1050,12'h048, 1,1,1,56'h1008,0,1);
      vecs[15] = mk(0,0,0,1,56'h0,   12'h048, 1,1,1,56'h1008,0,0);
      vecs[16] = mk(0,0,0,1,56'h0,   12'h010, 1,1,1,56'h1010,0,1);
      vecs[17] = mk(0,1,0,0,56'h2A38,12'hA3C, 1,1,0,56'h0,   1,0);
      vecs[18] = mk(0,0,0,0,56'h0,   12'hA3C, 1,1,0,56'h0,   0,1);
      vecs[19] = mk(0,0,1,0,56'h0,   12'hA40, 1,1,0,56'h0,   0,0);
      vecs[20] = mk(0,0,0,0,56'h0,   12'hA3C, 1,1,1,56'h2A38,0,1);
      vecs[21] = mk(0,0,0,1,56'h0,   12'hA3C, 1,1,1,56'h2A38,0,1);
      vecs[22] = mk(0,0,0,0,56'h0,   12'hA3C, 1,1,0,56'h0,   1,0);

      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0;
      mem_gnt_i = 1'b0; page_offset_i = 12'hFF8; entry_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      for (int i = 0; i < 23; i++) begin
         flush_i       = vecs[i].flush;
         valid_i       = vecs[i].valid;
         commit_i      = vecs[i].commit;
         mem_gnt_i     = vecs[i].gnt;
         entry_i       = mk_entry(vecs[i].addr);
         page_offset_i = vecs[i].poff;
         #1;
         check($sformatf("vec%0d", i),
               (ready_o == vecs[i].ready) && (commit_ready_o == vecs[i].cready) &&
               (mem_req_o == vecs[i].req) && (no_st_pending_o == vecs[i].nop) &&
               (page_offset_matches_o == vecs[i].match) &&
               (!vecs[i].req || (mem_entry_o.address == vecs[i].maddr)),
               $sformatf("got ready=%0b cready=%0b req=%0b addr=%h nop=%0b match=%0b, want ready=%0b cready=%0b req=%0b addr=%h nop=%0b match=%0b",
                         ready_o, commit_ready_o, mem_req_o, mem_entry_o.address, no_st_pending_o, page_offset_matches_o,
                         vecs[i].ready, vecs[i].cready, vecs[i].req, vecs[i].maddr, vecs[i].nop, vecs[i].match));
         tick();
      end
      flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; mem_gnt_i = 1'b0;
      page_offset_i = 12'hFF8;

      // fill committed queue to 8, then commit+grant together: commit must be refused
      for (int i = 0; i < 8; i++) begin
         push(56'h3000 + 56'(8 * i));
         do_commit();
      end
      check("commit_full", !commit_ready_o && mem_req_o && (mem_entry_o.address == 56'h3000),
            $sformatf("got cready=%0b req=%0b addr=%h, want cready=0 req=1 addr=3000",
                      commit_ready_o, mem_req_o, mem_entry_o.address));
      push(56'h3100);
      commit_i = 1'b1; mem_gnt_i = 1'b1;
      tick();
      commit_i = 1'b0; mem_gnt_i = 1'b0;
      check("full_commit_gnt", commit_ready_o && ready_o && (mem_entry_o.address == 56'h3008),
            $sformatf("got cready=%0b ready=%0b addr=%h, want cready=1 ready=1 addr=3008",
                      commit_ready_o, ready_o, mem_entry_o.address));
      drain_expect("drain7", 7, 56'h3008);
      check("spec_kept", !no_st_pending_o,
            $sformatf("got nop=%0b, want nop=0", no_st_pending_o));

      // commit_cnt = 3, then commit+grant together keeps it at 3
      push(56'h3108);
      push(56'h3110);
      repeat (3) do_commit();
      push(56'h3118);
      commit_i = 1'b1; mem_gnt_i = 1'b1;
      tick();
      commit_i = 1'b0; mem_gnt_i = 1'b0;
      drain_expect("drain3", 3, 56'h3108);
      check("all_drained", no_st_pending_o,
            $sformatf("got nop=%0b, want nop=1", no_st_pending_o));

      // reset while a request is outstanding
      push(56'h4008);
      push(56'h4010);
      do_commit();
      page_offset_i = 12'h008;
      #1;
      check("pre_reset_req", mem_req_o && page_offset_matches_o,
            $sformatf("got req=%0b match=%0b, want req=1 match=1", mem_req_o, page_offset_matches_o));
      rst_ni = 1'b0;
      tick();
      check("reset_mid_drain",
            ready_o && commit_ready_o && !mem_req_o && no_st_pending_o && !page_offset_matches_o,
            $sformatf("got ready=%0b cready=%0b req=%0b nop=%0b match=%0b, want 1 1 0 1 0",
                      ready_o, commit_ready_o, mem_req_o, no_st_pending_o, page_offset_matches_o));
      rst_ni = 1'b1;
      tick();
      check("post_reset_idle", !mem_req_o && no_st_pending_o,
            $sformatf("got req=%0b nop=%0b, want req=0 nop=1", mem_req_o, no_st_pending_o));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/lsu_store_buffer.md
LSU_STORE_BUFFER -- requirements
Module: lsu_store_buffer

Interface
REQ-001 SHALL have parameter SPEC_DEPTH, default 4, speculative queue entries (power of two, >=2).
REQ-002 SHALL have parameter COMMIT_DEPTH, default 8, committed queue entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all speculative entries.
REQ-006 SHALL have port valid_i  input  1  store from the store unit (fed by lsu_bypass path) to enqueue.
REQ-007 SHALL have port entry_i  input  store_entry_t  address[55:0], data[63:0], be[7:0], size[1:0].
REQ-008 SHALL have port ready_o  output  1  speculative queue not full.
REQ-009 SHALL have port commit_i  input  1  retire oldest speculative store.
REQ-010 SHALL have port commit_ready_o  output  1  committed queue not full.
REQ-011 SHALL have port page_offset_i  input  12  load page offset for hazard check.
REQ-012 SHALL have port page_offset_matches_o  output  1  any valid entry matches page_offset_i[11:3].
REQ-013 SHALL have port no_st_pending_o  output  1  both queues empty.
REQ-014 SHALL have ports mem_req_o output 1, mem_gnt_i input 1, mem_entry_o output store_entry_t  dcache write handshake.

Function
REQ-015 Push: valid_i && ready_o writes entry_i at spec tail; valid_i while !ready_o SHALL be dropped (assertion fires).
REQ-016 ready_o SHALL be (spec_cnt != SPEC_DEPTH), registered-count based, no same-cycle pop credit.
REQ-017 Commit: commit_i moves spec head into commit tail in the same cycle; spec_cnt-1, commit_cnt+1.
REQ-018 commit_i with spec empty or !commit_ready_o SHALL be ignored (assertion fires).
REQ-019 commit_ready_o SHALL be (commit_cnt != COMMIT_DEPTH).
REQ-020 Drain: mem_req_o SHALL equal (commit_cnt != 0); mem_entry_o = commit head, held stable until mem_gnt_i.
REQ-021 mem_req_o && mem_gnt_i pops commit head; simultaneous commit-push and grant-pop SHALL leave commit_cnt unchanged.
REQ-022 Simultaneous push and commit on spec queue SHALL leave spec_cnt unchanged; full-queue push still blocked per REQ-016.
REQ-023 flush_i SHALL zero spec_cnt, pointers and spec valid bits next cycle; it overrides same-cycle valid_i and commit_i.
REQ-024 flush_i SHALL NOT affect the committed queue; draining continues.
REQ-025 Pointers SHALL wrap modulo depth; counters are clog2(DEPTH)+1 bits.
REQ-026 page_offset_matches_o SHALL be combinational: OR over valid entries in both queues of address[11:3]==page_offset_i[11:3]; 0 when page_offset_i unused by caller is not special-cased.
REQ-027 no_st_pending_o SHALL be (spec_cnt==0 && commit_cnt==0), registered-count based.
REQ-028 Latency: entry committed in cycle N SHALL be offered on mem_req_o no earlier than cycle N+1.

Reset
REQ-029 On rst_ni low at clk_i edge: counts, pointers, valid bits zero; entry storage zeroed.
REQ-030 Post-reset outputs: ready_o=1, commit_ready_o=1, mem_req_o=0, no_st_pending_o=1, page_offset_matches_o=0.
REQ-031 Reset mid-drain SHALL abandon the outstanding request; mem_req_o low the following cycle.

Structure
REQ-032 store_entry_t and default depths SHALL live in ariane_pkg.
REQ-033 One sub-module sb_queue (circular FIFO exposing per-entry valid and address for matching, with clear input) SHALL be instantiated twice.

Verification
REQ-034 Push 4 stores (addr 0x1000,0x1008,0x1010,0x1018), no commit -> ready_o=0 after 4th; 5th valid_i dropped, spec_cnt stays 4.
REQ-035 Commit 2, mem_gnt_i held low -> mem_req_o=1, mem_entry_o.address=0x1000 stable; grant once -> next shows 0x1008.
REQ-036 3 spec + 2 committed, flush_i -> spec empty next cycle, mem_req_o stays 1, 2 grants drain, no_st_pending_o=1.
REQ-037 commit_i and mem_gnt_i same cycle with commit_cnt=8 (commit_ready_o=0) -> commit ignored; with commit_cnt=3 -> count stays 3.
REQ-038 Entry addr 0x2A38 in either queue, page_offset_i=0xA3C -> page_offset_matches_o=1; page_offset_i=0xA40 -> 0.
REQ-039 Assert rst_ni low with mem_req_o=1 -> next cycle all REQ-030 values.
